// File: rtl/ds_pkg.sv
// Shared constants and types for the delta-sigma audio path (modulator and decimator).
package ds_pkg;

  localparam int CLK_DIV_DEF    = 5;
  localparam int DECIM_LOG2_DEF = 8;
  localparam int AUDIO_W        = 14;
  localparam int AUDIO_MAX      = 8191;
  localparam int AUDIO_MIN      = -8192;

  typedef logic signed [AUDIO_W-1:0] audio_t;

  // A third-order CIC with ratio 2^d has gain 2^(3d); one extra bit carries the sign.
  function automatic int cic_width(input int decim_log2);
    return 3 * decim_log2 + 1;
  endfunction

  function automatic int out_shift(input int cic_w);
    return cic_w - 1 - (AUDIO_W - 1);
  endfunction

  localparam int CIC_W_DEF     = cic_width(DECIM_LOG2_DEF);
  localparam int OUT_SHIFT_DEF = out_shift(CIC_W_DEF);

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: en pulses for one clk_i cycle every CLK_DIV cycles.
module clk_en_div #(
  parameter int CLK_DIV = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic en
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  // en is registered, so the first pulse rises on the CLK_DIV-th edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      en    <= 1'b0;
    end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_q <= '0;
      en    <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      en    <= 1'b0;
    end
  end

endmodule

// File: rtl/ds_decimator.sv
// Third-order CIC decimator turning a 1-bit delta-sigma stream into 14-bit PCM.
module ds_decimator
  import ds_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bit_i,
  output logic [13:0] audio_o,
  output logic        audio_valid_o
);

  localparam int CW = cic_width(DECIM_LOG2);
  localparam int SH = out_shift(CW);
  localparam logic signed [CW-1:0] SAT_HI  = CW'(AUDIO_MAX);
  localparam logic signed [CW-1:0] SAT_LO  = CW'(AUDIO_MIN);
  localparam logic signed [CW-1:0] FS_WRAP = {1'b1, {(CW-1){1'b0}}};

  logic sync_q1, sync_q2;
  logic en;

  logic signed [CW-1:0] x;
  logic signed [CW-1:0] i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [DECIM_LOG2-1:0] dcnt_q;
  logic                  dec_strobe;
  logic [1:0]            warm_q;
  logic                  warm_done;

  logic signed [CW-1:0] c1_q, c2_q, c3_q, d1_q, d2_q, d3_q;
  logic                 ld1_q, ld2_q;
  logic                 emit1_q, emit2_q, emit3_q;
  logic                 pos1_q, pos2_q, pos3_q;
  logic signed [CW-1:0] shifted;
  audio_t               audio_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bit_i;
      sync_q2 <= sync_q1;
    end
  end

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_clk_en_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (en)
  );

  always_comb begin
    x          = sync_q2 ? CW'(1) : '1;
    i1_d       = i1_q + x;
    i2_d       = i2_q + i1_d;
    i3_d       = i3_q + i2_d;
    dec_strobe = en && (dcnt_q == '1);
    warm_done  = (warm_q == 2'd3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      dcnt_q <= '0;
    end else if (en) begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      dcnt_q <= dcnt_q + 1'b1;
    end
  end

  // Exactly +/-full scale is 2^(CW-1), which aliases to the same CW-bit pattern for both
  // signs. Only an all-equal window produces it, so the bit seen at the strobe resolves it.
  always_comb begin
    shifted = c3_q >>> SH;
    if ((c3_q == FS_WRAP) && pos3_q)  audio_next = audio_t'(AUDIO_MAX);
    else if (shifted > SAT_HI)        audio_next = audio_t'(AUDIO_MAX);
    else if (shifted < SAT_LO)        audio_next = audio_t'(AUDIO_MIN);
    else                              audio_next = shifted[AUDIO_W-1:0];
  end

  // audio_valid_o is a one-cycle strobe with no back-pressure; audio_o holds until the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c1_q          <= '0;
      c2_q          <= '0;
      c3_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      d3_q          <= '0;
      ld1_q         <= 1'b0;
      ld2_q         <= 1'b0;
      emit1_q       <= 1'b0;
      emit2_q       <= 1'b0;
      emit3_q       <= 1'b0;
      pos1_q        <= 1'b0;
      pos2_q        <= 1'b0;
      pos3_q        <= 1'b0;
      warm_q        <= 2'd0;
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
    end else begin
      ld1_q         <= dec_strobe;
      ld2_q         <= ld1_q;
      emit1_q       <= dec_strobe && warm_done;
      emit2_q       <= emit1_q;
      emit3_q       <= emit2_q;
      audio_valid_o <= emit3_q;
      if (dec_strobe) begin
        c1_q   <= i3_d - d1_q;
        d1_q   <= i3_d;
        pos1_q <= sync_q2;
        if (!warm_done) warm_q <= warm_q + 2'd1;
      end
      if (ld1_q) begin
        c2_q   <= c1_q - d2_q;
        d2_q   <= c1_q;
        pos2_q <= pos1_q;
      end
      if (ld2_q) begin
        c3_q   <= c2_q - d3_q;
        d3_q   <= c2_q;
        pos3_q <= pos2_q;
      end
      if (emit3_q) audio_o <= audio_next;
    end
  end

endmodule

// File: tb/tb_ds_decimator.sv
// Scoreboard bench for ds_decimator: patterned bitstreams, a delta-sigma source, reset abort.
module tb_ds_decimator;

  localparam int CLK_DIV = 5;
  localparam int R       = 256;
  localparam int PERIOD  = R * CLK_DIV;

  logic        clk_i;
  logic        rst_ni;
  logic        bit_i;
  logic [13:0] audio_o;
  logic        audio_valid_o;

  logic [13:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  int          ds_acc;
  int          last_audio;

  ds_decimator dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bit_i         (bit_i),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #10 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset(input int cycles);
    rst_ni = 1'b0;
    bit_i  = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1;
    check("rst_audio", int'($signed(audio_o)), 0);
    check("rst_valid", int'(audio_valid_o), 0);
    exp_q.delete();
    ds_acc     = 0;
    last_audio = 0;
    rst_ni     = 1'b1;
  endtask

  // first-order delta-sigma source with +/-8192 feedback
  function automatic logic ds_bit(input int audio);
    logic b;
    b      = (ds_acc >= 0);
    ds_acc = ds_acc + audio - (b ? 8192 : -8192);
    return b;
  endfunction

  function automatic logic next_bit(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2 == 0);
      3:       return (idx % 4 != 3);
      default: return ds_bit(2000);
    endcase
  endfunction

  function automatic int expected(input int mode);
    case (mode)
      0:       return 8191;
      1:       return -8192;
      2:       return 0;
      3:       return 4096;
      default: return 2000;
    endcase
  endfunction

  // One bit per enable period; the bit for en k is set just after edge 5(k-1)+1.
  task automatic run_test(input int mode, input int n_dec, input int abort_at, input bit rst_first);
    int n, k, last, d;
    logic [13:0] exp_v;
    if (rst_first) do_reset(4);
    n = 0; k = 0; last = 0;
    while (n < n_dec * PERIOD + 8) begin
      @(posedge clk_i);
      n++;
      #1;
      if (abort_at != 0 && n == abort_at) begin
        check("abort_inflight", exp_q.size(), 1);
        do_reset(3);
        return;
      end
      if (n % CLK_DIV == 1) begin
        k++;
        bit_i = next_bit(mode, k - 1);
        if (k % R == 0 && k / R >= 4) exp_q.push_back(14'(expected(mode)));
      end
      if (audio_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", n, 0);
        end else begin
          exp_v = exp_q.pop_front();
          if (mode == 4) begin
            d = int'($signed(audio_o)) - int'($signed(exp_v));
            check($sformatf("ds_audio_within4(audio=%0d)", $signed(audio_o)),
                  int'(d >= -4 && d <= 4), 1);
          end else begin
            check($sformatf("audio_mode%0d", mode), int'($signed(audio_o)), int'($signed(exp_v)));
          end
          if (last == 0) check("first_strobe_cycle", n, 4 * PERIOD + 4);
          else           check("strobe_spacing", n - last, PERIOD);
          last       = n;
          last_audio = int'($signed(audio_o));
        end
      end else if (last != 0 && (n - last) == PERIOD / 2) begin
        check("audio_hold", int'($signed(audio_o)), last_audio);
      end
      if (n == 2 * PERIOD) check("warmup_audio_zero", int'($signed(audio_o)), 0);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_ni   = 1'b0;
    bit_i    = 1'b0;
    run_test(0, 6, 0, 1'b1);
    run_test(1, 6, 0, 1'b1);
    run_test(2, 6, 0, 1'b1);
    run_test(3, 6, 0, 1'b1);
    run_test(4, 8, 0, 1'b1);
    // reset at D+2 of the 6th decimation, then warm-up must restart
    run_test(0, 6, 6 * PERIOD + 2, 1'b1);
    run_test(0, 5, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ds_decimator.md
DS_DECIMATOR -- requirements
Module: ds_decimator

Interface
REQ-001 Parameter CLK_DIV, default 5, clk_i cycles per bitstream sample (50 MHz -> 10 MHz bit rate).
REQ-002 Parameter DECIM_LOG2, default 8, log2 of decimation ratio R (R=256 -> 39.0625 kHz output rate).
REQ-003 Reset is rst_ni, asynchronous, active-low; clock is clk_i.
REQ-004 clk_i  input  1  system clock, 50 MHz.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 bit_i  input  1  asynchronous 1-bit delta-sigma stream from the comparator/modulator.
REQ-007 audio_o  output  14  signed PCM sample, held between strobes.
REQ-008 audio_valid_o  output  1  single-cycle strobe marking a new audio_o value.

Function
REQ-009 bit_i SHALL pass through a 2-flop synchronizer on clk_i before use.
REQ-010 An internal enable en SHALL pulse high for exactly one clk_i cycle every CLK_DIV cycles; first pulse on the CLK_DIV-th rising edge after reset release.
REQ-011 On en, the synchronized bit SHALL map to x = +1 (bit 1) or -1 (bit 0).
REQ-012 Three cascaded integrators I1 += x, I2 += I1, I3 += I2 SHALL update only on en, each CIC_W = 3*DECIM_LOG2+1 bits (25 bits at default), two's-complement wrap-around intentional, no saturation.
REQ-013 A decimation counter (DECIM_LOG2 bits) SHALL increment on en and wrap from R-1 to 0; decimation strobe D = en AND counter == R-1.
REQ-014 On D, I3 (post-update value) SHALL be captured into the comb input.
REQ-015 Three comb stages (y = in - in_delayed, delay = one decimated sample, CIC_W bits, wrap-around arithmetic) SHALL be pipelined one register per clk_i: comb1 at D+1, comb2 at D+2, comb3 at D+3.
REQ-016 At D+4, audio_o SHALL be loaded with comb3 >>> (CIC_W-1-13) (arithmetic shift 11 at default), saturated to [-8192, +8191], and audio_valid_o pulsed high for exactly that cycle.
REQ-017 Saturation: full-scale positive (+2^24) SHALL yield +8191; full-scale negative (-2^24) SHALL yield -8192.
REQ-018 The first 3 decimated results after reset (CIC warm-up) SHALL be discarded: no audio_valid_o, audio_o unchanged.
REQ-019 audio_o SHALL hold its value between strobes; audio_valid_o SHALL be low on all non-strobe cycles.
REQ-020 Comb pipeline stages SHALL never overlap: R*CLK_DIV (1280) >= 4 cycles guarantees this; DECIM_LOG2 < 2 is unsupported.
REQ-021 Output strobe period SHALL be exactly R*CLK_DIV clk_i cycles in steady state.

Reset
REQ-022 While rst_ni low: synchronizer, enable counter, integrators, decimation counter, comb registers and delays, warm-up counter SHALL be 0; audio_o = 0; audio_valid_o = 0.
REQ-023 Reset asserted mid-operation SHALL abort any in-flight comb pipeline with no strobe emitted; after release, warm-up (REQ-018) restarts.

Structure
REQ-024 Package ds_pkg SHALL hold CLK_DIV default, DECIM_LOG2 default, CIC_W derivation, output shift constant and the signed 14-bit audio sample typedef shared with the modulator.
REQ-025 The clock-enable divider SHALL be a separate sub-module clk_en_div (parameter CLK_DIV, output en), reusable by the modulator.
REQ-026 Target size 120-400 lines of RTL, single clock domain after the synchronizer.

Verification
REQ-027 bit_i constant 1 from reset -> first audio_valid_o at 4th decimation + 4 cycles, audio_o = +8191, all subsequent samples +8191.
REQ-028 bit_i constant 0 -> audio_o = -8192 on every strobe after warm-up.
REQ-029 bit_i alternating 1,0 per en -> audio_o = 0 on every strobe after warm-up.
REQ-030 bit_i repeating 1,1,1,0 per en -> audio_o = +4096 after warm-up; strobe spacing exactly 1280 clk_i cycles.
REQ-031 Feed bitstream from delta_sigma driven by constant audio_i = 2000 -> decoded audio_o within +/-4 LSB of 2000 after warm-up.
REQ-032 Assert rst_ni low for 3 cycles at D+2 -> no strobe at D+4, all outputs 0, next valid strobe only after 4 further decimations.
